// File: rtl/imem_responder_pkg.sv
// Shared constants and state type for the instruction-memory responder.
// Latency/backpressure: n/a (types only).
package imem_responder_pkg;

    localparam int              DATA_WIDTH = 32;
    localparam int              IMEM_DEPTH = 1024;
    localparam logic [31:0]     BOOT_ADDR  = 32'h0000_0000;
    localparam logic [31:0]     PC_STEP    = 32'd4;
    localparam logic [31:0]     NOP_INSTR  = 32'h0000_0013;

    typedef enum logic {
        IMEM_CLEAR = 1'b0,
        IMEM_READY = 1'b1
    } imem_state_t;

endpackage

// File: rtl/imem_responder_if.sv
// Fetch port (PC side) and boot-loader port of the instruction memory.
// Latency: response one cycle after accept; backpressure via stall_req.
interface imem_responder_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  fetch_req;
    logic [DATA_WIDTH-1:0] fetch_addr;
    logic                  fetch_valid;
    logic [DATA_WIDTH-1:0] fetch_instr;
    logic                  fetch_err;
    logic                  stall_req;
    logic                  load_we;
    logic [DATA_WIDTH-1:0] load_addr;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_ack;

    modport master (
        output fetch_req, fetch_addr, load_we, load_addr, load_data,
        input  fetch_valid, fetch_instr, fetch_err, stall_req, load_ack
    );

    modport slave (
        input  fetch_req, fetch_addr, load_we, load_addr, load_data,
        output fetch_valid, fetch_instr, fetch_err, stall_req, load_ack
    );

endinterface

// File: rtl/imem_ram.sv
// Single-port synchronous RAM shaped for block-RAM inference.
// Latency: read data one cycle after address; no backpressure.
module imem_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024,
    localparam int AW        = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: scrubs to NOP after reset, then serves PC fetches and loader writes.
// Latency: fetch data exactly one cycle after accept; stall_req while scrubbing or while the loader owns the port.
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    MEM_DEPTH  = 1024,
    parameter logic [DATA_WIDTH-1:0] BOOT_ADDR  = '0,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = DATA_WIDTH'(32'h0000_0013)
) (
    input  logic             clk,
    input  logic             rst,
    imem_responder_if.slave  bus
);

    localparam int                    AW   = $clog2(MEM_DEPTH);
    localparam logic [AW-1:0]         LAST = AW'(MEM_DEPTH - 1);
    localparam logic [DATA_WIDTH-1:0] SPAN = DATA_WIDTH'(4 * MEM_DEPTH);

    imem_state_t state, state_nxt;
    logic [AW-1:0] clr_cnt;

    logic fetch_bad, load_bad, fetch_ok, load_ok;
    logic [AW-1:0] fetch_idx, load_idx;

    logic                  ram_we;
    logic [AW-1:0]         ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata, ram_rdata;

    logic                  rd_pend;
    logic [DATA_WIDTH-1:0] instr_hold;

    // Subtraction is unsigned, so addresses below BOOT_ADDR wrap high and fail the range test.
    function automatic logic addr_bad(input logic [DATA_WIDTH-1:0] a);
        return (a[1:0] != 2'b00) || ((a - BOOT_ADDR) >= SPAN);
    endfunction

    function automatic logic [AW-1:0] addr_idx(input logic [DATA_WIDTH-1:0] a);
        return AW'((a - BOOT_ADDR) >> 2);
    endfunction

    always_comb begin
        state_nxt = state;
        if (state == IMEM_CLEAR && clr_cnt == LAST) begin
            state_nxt = IMEM_READY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IMEM_CLEAR;
            clr_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == IMEM_CLEAR) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
        end
    end

    assign fetch_bad = addr_bad(bus.fetch_addr);
    assign load_bad  = addr_bad(bus.load_addr);
    assign fetch_idx = addr_idx(bus.fetch_addr);
    assign load_idx  = addr_idx(bus.load_addr);

    // Loader wins the single RAM port; the PC must hold its request while stalled.
    assign load_ok       = (state == IMEM_READY) && bus.load_we;
    assign fetch_ok      = (state == IMEM_READY) && bus.fetch_req && !bus.load_we;
    assign bus.stall_req = bus.fetch_req && ((state == IMEM_CLEAR) || bus.load_we);

    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = fetch_idx;
        ram_wdata = bus.load_data;
        if (state == IMEM_CLEAR) begin
            ram_we    = rst;
            ram_addr  = clr_cnt;
            ram_wdata = NOP_WORD;
        end else if (bus.load_we) begin
            ram_we   = rst && !load_bad;
            ram_addr = load_idx;
        end
    end

    imem_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Good reads show RAM data directly; otherwise the last shown word is held.
    assign bus.fetch_instr = rd_pend ? ram_rdata : instr_hold;

    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.fetch_valid <= 1'b0;
            bus.fetch_err   <= 1'b0;
            bus.load_ack    <= 1'b0;
            rd_pend         <= 1'b0;
            instr_hold      <= NOP_WORD;
        end else begin
            bus.fetch_valid <= fetch_ok;
            bus.fetch_err   <= fetch_ok && fetch_bad;
            bus.load_ack    <= load_ok;
            rd_pend         <= fetch_ok && !fetch_bad;
            instr_hold      <= (fetch_ok && fetch_bad) ? NOP_WORD : bus.fetch_instr;
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Randomized and directed bench for imem_responder against a cycle-level reference model.
module tb_imem_responder;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BOOT  = 32'h0000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clk;
    logic rst;

    imem_responder_if #(.DATA_WIDTH(32)) bus ();

    imem_responder #(
        .DATA_WIDTH (32),
        .MEM_DEPTH  (DEPTH),
        .BOOT_ADDR  (BOOT),
        .NOP_WORD   (NOP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    logic [31:0] mdl [DEPTH];
    int          clear_left = DEPTH;
    logic [31:0] last_instr = NOP;
    logic        obs_stall  = 1'b0;

    function automatic logic bad_addr(input logic [31:0] a);
        logic [31:0] off;
        off = a - BOOT;
        return (a[1:0] != 2'b00) || (off >= 32'(4 * DEPTH));
    endfunction

    function automatic int word_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - BOOT;
        return int'(off >> 2);
    endfunction

    // One clock: apply inputs, check stall, advance, check registered outputs.
    task automatic do_cycle(input logic r, input logic fq, input logic [31:0] fa,
                            input logic lw, input logic [31:0] la, input logic [31:0] ld,
                            input string tag);
        logic        e_stall, e_valid, e_err, e_ack, chk_stall;
        logic [31:0] e_instr;
        rst            = r;
        bus.fetch_req  = fq;
        bus.fetch_addr = fa;
        bus.load_we    = lw;
        bus.load_addr  = la;
        bus.load_data  = ld;
        #1;
        e_stall = 1'b0; e_valid = 1'b0; e_err = 1'b0; e_ack = 1'b0;
        e_instr = last_instr; chk_stall = 1'b1;
        if (!r) begin
            chk_stall  = 1'b0;
            e_instr    = NOP;
            clear_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) mdl[i] = NOP;
        end else if (clear_left > 0) begin
            e_stall = fq;
            clear_left--;
        end else begin
            e_stall = fq && lw;
            e_ack   = lw;
            if (lw && !bad_addr(la)) mdl[word_of(la)] = ld;
            if (fq && !lw) begin
                e_valid = 1'b1;
                e_err   = bad_addr(fa);
                e_instr = e_err ? NOP : mdl[word_of(fa)];
            end
        end
        obs_stall = bus.stall_req;
        if (chk_stall) begin
            checks++;
            if (bus.stall_req !== e_stall) begin
                errors++;
                $display("FAIL %s stall_req: got %b want %b", tag, bus.stall_req, e_stall);
            end
        end
        last_instr = e_instr;
        @(posedge clk);
        #1;
        checks++;
        if (bus.fetch_valid !== e_valid) begin
            errors++;
            $display("FAIL %s fetch_valid: got %b want %b", tag, bus.fetch_valid, e_valid);
        end
        checks++;
        if (bus.fetch_err !== e_err) begin
            errors++;
            $display("FAIL %s fetch_err: got %b want %b", tag, bus.fetch_err, e_err);
        end
        checks++;
        if (bus.fetch_instr !== e_instr) begin
            errors++;
            $display("FAIL %s fetch_instr: got %h want %h", tag, bus.fetch_instr, e_instr);
        end
        checks++;
        if (bus.load_ack !== e_ack) begin
            errors++;
            $display("FAIL %s load_ack: got %b want %b", tag, bus.load_ack, e_ack);
        end
    endtask

    task automatic idle(input string tag);
        do_cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, tag);
    endtask

    task automatic fetch(input logic [31:0] a, input string tag);
        do_cycle(1'b1, 1'b1, a, 1'b0, 32'h0, 32'h0, tag);
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d, input string tag);
        do_cycle(1'b1, 1'b0, 32'h0, 1'b1, a, d, tag);
    endtask

    task automatic expect_resp(input logic [31:0] instr, input logic err, input string tag);
        checks++;
        if (bus.fetch_valid !== 1'b1 || bus.fetch_instr !== instr || bus.fetch_err !== err) begin
            errors++;
            $display("FAIL %s response: got v=%b i=%h e=%b want v=1 i=%h e=%b",
                     tag, bus.fetch_valid, bus.fetch_instr, bus.fetch_err, instr, err);
        end
    endtask

    // Holds a fetch of 0x0 until accepted; the stalled-cycle count must equal DEPTH.
    task automatic wait_clear(input string tag);
        int n;
        bit done;
        n = 0;
        done = 0;
        for (int i = 0; i < DEPTH + 8 && !done; i++) begin
            do_cycle(1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, tag);
            if (obs_stall) n++;
            else done = 1;
        end
        checks++;
        if (!done || n != DEPTH) begin
            errors++;
            $display("FAIL %s stall_cycles: got %0d (accepted=%0d) want %0d", tag, n, done, DEPTH);
        end
    endtask

    task automatic test_reset();
        do_cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, "reset0");
        do_cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, "reset1");
        wait_clear("reset_clear");
        expect_resp(NOP, 1'b0, "reset_first_fetch");
        idle("reset_idle");
    endtask

    task automatic test_load_fetch();
        load(32'h0,  32'h0050_0093, "load0");
        load(32'h4,  32'h0010_8113, "load4");
        load(32'h14, 32'h0000_0013, "load14");
        fetch(32'h0, "fetch0");
        expect_resp(32'h0050_0093, 1'b0, "fetch0_data");
        fetch(32'h4, "fetch4");
        expect_resp(32'h0010_8113, 1'b0, "fetch4_data");
        idle("lf_idle");
        idle("lf_hold");
    endtask

    task automatic test_bad_addr();
        fetch(32'h2, "mis2");
        expect_resp(NOP, 1'b1, "mis2_resp");
        fetch(32'h1000, "oor1000");
        expect_resp(NOP, 1'b1, "oor1000_resp");
        fetch(32'hFFFF_FFFC, "wrapneg");
        fetch(32'hFFC, "lastword");
        load(32'h1004, 32'h1234_5678, "load_oor");
        load(32'h3, 32'h1234_5678, "load_mis");
        idle("bad_idle");
    endtask

    task automatic test_load_priority();
        do_cycle(1'b1, 1'b1, 32'h18, 1'b1, 32'h18, 32'hDEAD_BEEF, "prio_collide");
        fetch(32'h18, "prio_held");
        expect_resp(32'hDEAD_BEEF, 1'b0, "prio_newdata");
        idle("prio_idle");
    endtask

    task automatic test_random();
        logic [31:0] fa, la;
        for (int i = 0; i < 400; i++) begin
            fa = ($urandom_range(0, 3) != 0) ? (32'($urandom_range(0, 31)) << 2) : $urandom;
            la = ($urandom_range(0, 3) != 0) ? (32'($urandom_range(0, 31)) << 2) : $urandom;
            do_cycle(1'b1, 1'($urandom_range(0, 1)), fa, 1'($urandom_range(0, 2) == 0),
                     la, $urandom, "random");
        end
        idle("rand_idle");
    endtask

    task automatic test_reset_mid_clear();
        load(32'h0, 32'hCAFE_F00D, "mc_preload");
        do_cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, "mc_rst_a");
        for (int i = 0; i < DEPTH / 2; i++)
            do_cycle(1'b1, 1'b1, 32'h8, 1'b1, 32'h8, 32'h1111_2222, "mc_clear_load");
        do_cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, "mc_rst_b");
        wait_clear("mc_restart");
        expect_resp(NOP, 1'b0, "mc_word0_scrubbed");
        fetch(32'h8, "mc_fetch8");
        expect_resp(NOP, 1'b0, "mc_word8_nop");
        idle("mc_idle");
    endtask

    task automatic test_reset_mid_response();
        load(32'h4, 32'h0BAD_F00D, "mr_load");
        fetch(32'h4, "mr_fetch");
        do_cycle(1'b0, 1'b1, 32'h4, 1'b0, 32'h0, 32'h0, "mr_rst");
        checks++;
        if (bus.fetch_valid !== 1'b0) begin
            errors++;
            $display("FAIL mr_dropped fetch_valid: got %b want 0", bus.fetch_valid);
        end
        wait_clear("mr_clear");
    endtask

    initial begin
        rst = 1'b0;
        bus.fetch_req = 1'b0; bus.fetch_addr = '0;
        bus.load_we = 1'b0; bus.load_addr = '0; bus.load_data = '0;
        for (int i = 0; i < DEPTH; i++) mdl[i] = NOP;
        test_reset();
        test_load_fetch();
        test_bad_addr();
        test_load_priority();
        test_random();
        test_reset_mid_clear();
        test_reset_mid_response();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder: the serving end of the fetch interface driven by the program counter.
- Accepts fetch requests carrying the PC address and returns the 32-bit instruction one cycle later.
- Raises a stall toward the PC whenever it cannot accept a request.
- Holds a word-addressed program store that a boot loader port writes; on reset the store is scrubbed to NOP before fetches are served.

Parameters:
- DATA_WIDTH, 32, instruction/data width (`DATA_WIDTH).
- MEM_DEPTH, 1024, number of 32-bit words; must be a power of two.
- BOOT_ADDR, 32'h0000_0000, byte address of word 0 (`BOOT_ADDR).
- NOP_WORD, 32'h0000_0013, scrub value (addi x0,x0,0).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-low: sampled at posedge clk, rst==0 resets the block.
- fetch_req  in  1  PC requests an instruction this cycle.
- fetch_addr  in  DATA_WIDTH  byte address (pc_out).
- fetch_valid  out  1  fetch_instr/fetch_err valid this cycle.
- fetch_instr  out  DATA_WIDTH  returned instruction.
- fetch_err  out  1  returned access was misaligned or out of range.
- stall_req  out  1  request not accepted this cycle; drives PC stall.
- load_we  in  1  loader write strobe.
- load_addr  in  DATA_WIDTH  loader byte address.
- load_data  in  DATA_WIDTH  loader write data.
- load_ack  out  1  loader write committed (registered pulse).

Behaviour:
- Reset (rst==0 at posedge):
  - state<=CLEAR, clr_cnt<=0.
  - fetch_valid, fetch_err, load_ack <= 0; fetch_instr <= NOP_WORD.
  - Reset asserted mid-CLEAR restarts the scrub from word 0.
  - Reset asserted mid-response drops the pending response (no fetch_valid).
- FSM states:
  - CLEAR: writes NOP_WORD to word clr_cnt each cycle and increments clr_cnt. On clr_cnt==MEM_DEPTH-1, the last word is written and the FSM goes to READY. CLEAR lasts exactly MEM_DEPTH cycles.
  - READY: serves fetches and loader writes.
- Stall:
  - stall_req is combinational: fetch_req && (state==CLEAR || load_we).
  - In CLEAR, load_we is ignored and load_ack stays 0.
- Address check, word index = (addr - BOOT_ADDR) >> 2:
  - misaligned when addr[1:0] != 0;
  - out of range when (addr - BOOT_ADDR) >= 4*MEM_DEPTH, computed unsigned so addresses below BOOT_ADDR wrap and count as out of range.
- Fetch accept: in READY with fetch_req && !load_we.
  - Next cycle: fetch_valid=1, and fetch_instr = mem[index], fetch_err=0.
  - On a bad address: fetch_instr=NOP_WORD, fetch_err=1.
  - Latency is exactly 1 cycle. Back-to-back requests give back-to-back responses.
- With no accept, fetch_valid=0 next cycle and fetch_instr holds its last value.
- Loader write in READY with load_we:
  - A good address writes mem[index] at the posedge and load_ack=1 next cycle.
  - A bad address is dropped, with load_ack=1 and no write.
  - The loader has priority over fetch. A simultaneous fetch is stalled and must be held by the PC, then accepted next cycle and returns the newly written data when the addresses match.
- Memory: single port, synchronous read. Write-before-read ordering is guaranteed by priority; there is no bypass path.
- Widths: all arithmetic is DATA_WIDTH unsigned. The index uses $clog2(MEM_DEPTH) bits.

Decomposition:
- rv32i_params.vh gains:
  - `IMEM_DEPTH
  - `NOP_INSTR
  - state encodings `IMEM_CLEAR / `IMEM_READY
- The existing `DATA_WIDTH, `BOOT_ADDR and `PC_STEP are reused.
- One sub-module, imem_ram: single-port synchronous RAM (we, addr, wdata, rdata) so synthesis infers BRAM. imem_responder holds the FSM, address check, arbitration and output registers.

Test Plan:
- Reset with rst=0 for 2 cycles, then rst=1, fetch_req=1 at 0x0 -> stall_req=1 for MEM_DEPTH cycles, then fetch_valid=1 next cycle with fetch_instr=32'h0000_0013, fetch_err=0.
- Load 0x00500093 @0x0, 0x00108113 @0x4, 0x00000013 @0x14, each -> load_ack pulse one cycle later. Then sequential fetch 0x0, 0x4 -> responses 0x00500093, 0x00108113 on consecutive cycles.
- Fetch 0x2 -> fetch_err=1, fetch_instr=0x00000013. Fetch 0x1000 (MEM_DEPTH=1024) -> fetch_err=1.
- load_we @0x18 with data 0xDEADBEEF and fetch_req @0x18 in the same cycle -> stall_req=1, load_ack next cycle. The held fetch is accepted a cycle later and returns 0xDEADBEEF.
- rst=0 pulsed halfway through CLEAR -> clr_cnt restarts at 0, stall persists MEM_DEPTH cycles after release. A word previously loaded reads back 0x00000013.
- Loader write during CLEAR @0x8 -> no load_ack. After CLEAR, fetch 0x8 returns 0x00000013.
